// File: rtl/par_check_sink.sv
// Checking traffic sink for the parallel NoC: accepts flits under a valid/busy
// handshake, throttles with an LFSR, and checks destination and per-source sequence.
module par_check_sink #(
  parameter int unsigned ID     = 0,
  parameter int unsigned NODES  = 9,
  parameter int unsigned HOSP   = 255,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PAY_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PAY_W+ADDR_W-1:0]   data,
  input  logic                      valid,
  output logic                      busy,
  output logic [19:0]               rx_count,
  output logic [15:0]               err_dest_count,
  output logic [15:0]               err_seq_count,
  output logic [ADDR_W-1:0]         last_src,
  output logic [PAY_W-ADDR_W-1:0]   last_seq,
  output logic                      err
);

  localparam int unsigned SEQ_W  = PAY_W - ADDR_W;
  localparam int unsigned DATA_W = PAY_W + ADDR_W;
  localparam int unsigned RX_W   = 20;
  localparam int unsigned ERR_W  = 16;
  localparam int unsigned LFSR_W = 8;

  localparam logic [LFSR_W-1:0] SEED_RAW = {4'(ID), 4'hA};
  localparam logic [LFSR_W-1:0] SEED     = (SEED_RAW == '0) ? 8'h01 : SEED_RAW;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              busy_q, busy_d;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic [ERR_W-1:0]  err_dest_q, err_dest_d;
  logic [ERR_W-1:0]  err_seq_q, err_seq_d;
  logic [ADDR_W-1:0] last_src_q, last_src_d;
  logic [SEQ_W-1:0]  last_seq_q, last_seq_d;
  logic              err_q, err_d;
  logic [SEQ_W-1:0]  exp_q [NODES];
  logic [SEQ_W-1:0]  exp_d [NODES];

  logic [ADDR_W-1:0] dest, src;
  logic [SEQ_W-1:0]  seq, exp_sel;
  logic              accept, src_ok, dest_bad, seq_bad;

  assign dest   = data[ADDR_W-1:0];
  assign src    = data[2*ADDR_W-1:ADDR_W];
  assign seq    = data[DATA_W-1:2*ADDR_W];
  assign accept = valid & ~busy_q;

  // Throttle, field checks and saturating statistics
  always_comb begin
    lfsr_d     = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    busy_d     = (lfsr_d > LFSR_W'(HOSP));
    rx_d       = rx_q;
    err_dest_d = err_dest_q;
    err_seq_d  = err_seq_q;
    last_src_d = last_src_q;
    last_seq_d = last_seq_q;
    err_d      = err_q;
    exp_d      = exp_q;
    exp_sel    = '0;
    for (int i = 0; i < int'(NODES); i++) begin
      if (src == ADDR_W'(i)) exp_sel = exp_q[i];
    end
    src_ok   = (32'(src) < NODES);
    dest_bad = (dest != ADDR_W'(ID));
    seq_bad  = !src_ok || (seq != exp_sel);

    if (accept) begin
      rx_d       = (rx_q == '1) ? rx_q : rx_q + RX_W'(1);
      last_src_d = src;
      last_seq_d = seq;
      if (dest_bad) err_dest_d = (err_dest_q == '1) ? err_dest_q : err_dest_q + ERR_W'(1);
      if (seq_bad)  err_seq_d  = (err_seq_q == '1) ? err_seq_q : err_seq_q + ERR_W'(1);
      if (dest_bad || seq_bad) err_d = 1'b1;
      // Table resynchronises to the received sequence even after an error
      for (int i = 0; i < int'(NODES); i++) begin
        if (src_ok && (src == ADDR_W'(i))) exp_d[i] = seq + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q     <= SEED;
      busy_q     <= 1'b1;
      rx_q       <= '0;
      err_dest_q <= '0;
      err_seq_q  <= '0;
      last_src_q <= '0;
      last_seq_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(NODES); i++) exp_q[i] <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      busy_q     <= busy_d;
      rx_q       <= rx_d;
      err_dest_q <= err_dest_d;
      err_seq_q  <= err_seq_d;
      last_src_q <= last_src_d;
      last_seq_q <= last_seq_d;
      err_q      <= err_d;
      for (int i = 0; i < int'(NODES); i++) exp_q[i] <= exp_d[i];
    end
  end

  assign busy           = busy_q;
  assign rx_count       = rx_q;
  assign err_dest_count = err_dest_q;
  assign err_seq_count  = err_seq_q;
  assign last_src       = last_src_q;
  assign last_seq       = last_seq_q;
  assign err            = err_q;

endmodule

// File: tb/tb_par_check_sink.sv
// Scoreboard bench for par_check_sink: reference model of the sequence table and
// counters feeds a queue; a monitor compares on every accepting edge.
`timescale 1ns/1ps
module tb_par_check_sink;

  localparam int NODES = 9;
  localparam int SEQ_M = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main DUT: ID=4, never throttles
  logic        rst_n, d_valid, d_busy, d_err;
  logic [19:0] d_data, d_rx;
  logic [15:0] d_ed, d_es;
  logic [3:0]  d_lsrc;
  logic [11:0] d_lseq;

  par_check_sink #(.ID(4), .NODES(9), .HOSP(255), .ADDR_W(4), .PAY_W(16)) u_dut (
    .clk(clk), .reset(rst_n), .data(d_data), .valid(d_valid), .busy(d_busy),
    .rx_count(d_rx), .err_dest_count(d_ed), .err_seq_count(d_es),
    .last_src(d_lsrc), .last_seq(d_lseq), .err(d_err));

  // Throttle DUTs: HOSP=0 and HOSP=128, valid held high
  logic        rst_t, t_valid;
  logic [19:0] t_data;
  logic        t0_busy, t0_err, t1_busy, t1_err;
  logic [19:0] t0_rx, t1_rx;
  logic [15:0] t0_ed, t0_es, t1_ed, t1_es;
  logic [3:0]  t0_lsrc, t1_lsrc;
  logic [11:0] t0_lseq, t1_lseq;

  par_check_sink #(.ID(4), .NODES(9), .HOSP(0), .ADDR_W(4), .PAY_W(16)) u_thr0 (
    .clk(clk), .reset(rst_t), .data(t_data), .valid(t_valid), .busy(t0_busy),
    .rx_count(t0_rx), .err_dest_count(t0_ed), .err_seq_count(t0_es),
    .last_src(t0_lsrc), .last_seq(t0_lseq), .err(t0_err));

  par_check_sink #(.ID(4), .NODES(9), .HOSP(128), .ADDR_W(4), .PAY_W(16)) u_thr1 (
    .clk(clk), .reset(rst_t), .data(t_data), .valid(t_valid), .busy(t1_busy),
    .rx_count(t1_rx), .err_dest_count(t1_ed), .err_seq_count(t1_es),
    .last_src(t1_lsrc), .last_seq(t1_lseq), .err(t1_err));

  // Reference model state
  typedef struct {
    int rx; int ed; int es; int src; int seq; int err;
  } exp_t;

  exp_t q_exp[$];
  int   m_tbl[NODES];
  int   m_rx, m_ed, m_es, m_src, m_seq, m_err;

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    foreach (m_tbl[i]) m_tbl[i] = 0;
    m_rx = 0; m_ed = 0; m_es = 0; m_src = 0; m_seq = 0; m_err = 0;
  endtask

  task automatic model_accept(input int dest, input int src, input int seq);
    exp_t e;
    bit dbad, sbad;
    dbad = (dest != 4);
    sbad = (src >= NODES) || (seq != m_tbl[src % 16 < NODES ? src : 0]);
    if (src >= NODES) sbad = 1;
    else m_tbl[src] = (seq + 1) % SEQ_M;
    m_rx = sat(m_rx, 20'hFFFFF);
    if (dbad) m_ed = sat(m_ed, 16'hFFFF);
    if (sbad) m_es = sat(m_es, 16'hFFFF);
    if (dbad || sbad) m_err = 1;
    m_src = src; m_seq = seq;
    e = '{rx: m_rx, ed: m_ed, es: m_es, src: m_src, seq: m_seq, err: m_err};
    q_exp.push_back(e);
  endtask

  // Drive one flit, waiting (bounded) for busy to drop
  task automatic send(input int dest, input int src, input int seq);
    int n = 0;
    @(negedge clk);
    while (d_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_idle", int'(d_busy), 0);
    d_data  = {12'(seq), 4'(src), 4'(dest)};
    d_valid = 1'b1;
    model_accept(dest, src, seq);
    @(posedge clk);
    #1 d_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, int'(d_busy), 1);
    check({tag, "_rx"}, int'(d_rx), 0);
    check({tag, "_ed"}, int'(d_ed), 0);
    check({tag, "_es"}, int'(d_es), 0);
    check({tag, "_lsrc"}, int'(d_lsrc), 0);
    check({tag, "_lseq"}, int'(d_lseq), 0);
    check({tag, "_err"}, int'(d_err), 0);
  endtask

  // Asynchronous 1 ns reset pulse between clock edges
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #0.5 check_reset_vals("rst_pulse");
    #0.5 rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare on every accepting edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && d_valid && !d_busy) begin
        @(negedge clk);
        if (q_exp.size() == 0) begin
          check("sb_unexpected_accept", 1, 0);
        end else begin
          e = q_exp.pop_front();
          check("sb_rx", int'(d_rx), e.rx);
          check("sb_err_dest", int'(d_ed), e.ed);
          check("sb_err_seq", int'(d_es), e.es);
          check("sb_last_src", int'(d_lsrc), e.src);
          check("sb_last_seq", int'(d_lseq), e.seq);
          check("sb_err", int'(d_err), e.err);
        end
      end
    end
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  initial begin
    logic [7:0] lf;
    int c0, c1, s, sq, dst;
    bit mb0, mb1, seen0, seen1;

    rst_n = 1'b0; d_valid = 1'b0; d_data = '0;
    rst_t = 1'b0; t_valid = 1'b1; t_data = {12'd0, 4'd0, 4'd4};
    model_reset();

    // Throttle behaviour
    repeat (2) @(negedge clk);
    check("thr0_reset_busy", int'(t0_busy), 1);
    check("thr1_reset_busy", int'(t1_busy), 1);
    rst_t = 1'b1;
    lf = {4'h4, 4'hA}; mb0 = 1; mb1 = 1; c0 = 0; c1 = 0; seen0 = 0; seen1 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!mb0) c0++;
      if (!mb1) c1++;
      lf  = lfsr_step(lf);
      mb0 = (lf > 0);
      mb1 = (lf > 128);
      if (mb1) seen1 = 1; else seen0 = 1;
      check("thr0_busy", int'(t0_busy), int'(mb0));
      check("thr1_busy", int'(t1_busy), int'(mb1));
    end
    check("thr0_rx", int'(t0_rx), c0);
    check("thr1_rx", int'(t1_rx), c1);
    check("thr1_toggles", int'(seen0 && seen1), 1);
    t_valid = 1'b0;

    // Main DUT reset state
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single packet
    send(4, 2, 0);
    @(negedge clk);
    check("single_rx", int'(d_rx), 1);
    check("single_err", int'(d_err), 0);

    // In-order interleaved stream of 100
    pulse_reset();
    for (int i = 0; i < 100; i++) send(4, i % NODES, m_tbl[i % NODES]);
    @(negedge clk);
    check("stream_rx", int'(d_rx), 100);
    check("stream_es", int'(d_es), 0);

    // 20 more, then asynchronous reset, then seq=0 from every src
    for (int i = 0; i < 20; i++) begin
      s = $urandom_range(0, NODES - 1);
      send(4, s, m_tbl[s]);
    end
    pulse_reset();
    for (int i = 0; i < NODES; i++) send(4, i, 0);
    @(negedge clk);
    check("post_reset_es", int'(d_es), 0);

    // Sequence gap with resync, then the 4095 -> 0 wrap
    pulse_reset();
    send(4, 3, 0); send(4, 3, 1); send(4, 3, 3);
    @(negedge clk);
    check("gap_es_third", int'(d_es), 1);
    send(4, 3, 4);
    @(negedge clk);
    check("gap_es_fourth", int'(d_es), 1);
    check("gap_err", int'(d_err), 1);
    send(4, 1, 4095); send(4, 1, 0); send(4, 1, 1);

    // Wrong dest and out-of-range src on one packet
    pulse_reset();
    send(5, 12, 7);
    @(negedge clk);
    check("dual_ed", int'(d_ed), 1);
    check("dual_es", int'(d_es), 1);
    check("dual_rx", int'(d_rx), 1);

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      s   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NODES - 1));
      dst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 4;
      sq  = (s < NODES && $urandom_range(0, 5) != 0) ? m_tbl[s] : int'($urandom_range(0, SEQ_M - 1));
      send(dst, s, sq);
    end

    // Saturation of err_dest_count
    @(negedge clk);
    force u_dut.err_dest_d = 16'hFFFF;
    @(negedge clk);
    release u_dut.err_dest_d;
    m_ed = 16'hFFFF;
    check("sat_preload", int'(d_ed), 16'hFFFF);
    send(9, 0, m_tbl[0]);
    send(9, 0, m_tbl[0]);
    @(negedge clk);
    check("sat_hold", int'(d_ed), 16'hFFFF);

    repeat (3) @(negedge clk);
    check("sb_drain", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/par_check_sink.md
# par_check_sink

Checking traffic sink for the parallel NoC. It attaches to a router's local output port, which carries `tx_l_data` and `tx_l_valid`. It is the receiving end of the parallel traffic source. The block accepts packets under a valid/busy handshake and throttles acceptance with an LFSR-driven hospitality setting. It checks each packet's destination and its per-source sequence number, and exposes saturating statistics counters to the bench.

## Interface
- `ID`, 0: node address of this sink; the expected destination field.
- `NODES`, 9: number of sources tracked in the sequence table.
- `HOSP`, 255: hospitality, 0..255. 255 never asserts busy; 0 always asserts busy.
- `ADDR_W`, 4: address field width.
- `PAY_W`, 16: payload width. `SEQ_W = PAY_W - ADDR_W`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data`  in  PAY_W+ADDR_W  flit. Field layout:
  - `[ADDR_W-1:0]`: dest.
  - `[2*ADDR_W-1:ADDR_W]`: src.
  - `[PAY_W+ADDR_W-1:2*ADDR_W]`: seq.
- `valid`  in  1  flit on `data` is valid.
- `busy`  out  1  sink refuses the flit this cycle. Registered.
- `rx_count`  out  20  packets accepted.
- `err_dest_count`  out  16  accepted packets with dest ≠ ID.
- `err_seq_count`  out  16  accepted packets with a sequence error or an out-of-range src.
- `last_src`  out  ADDR_W  src of the most recently accepted packet.
- `last_seq`  out  SEQ_W  seq of the most recently accepted packet.
- `err`  out  1  sticky; set on the first error of either kind.

## Operation
- **Accept:** a transfer occurs on a rising edge when `valid`=1 and `busy`=0. A flit with `busy`=1 is not consumed; the sender holds it.
- **Throttle:**
  - 8-bit Fibonacci LFSR, taps 8,6,5,4. Seed `{ID[3:0],4'hA}`; if the seed computes to zero, seed with 8'h01.
  - The LFSR advances every cycle.
  - `busy <= (lfsr_next > HOSP)`.
- **Destination check:** on accept, if dest ≠ ID, `err_dest_count` increments. The packet is still counted in `rx_count`.
- **Sequence check:**
  - Table `exp[0..NODES-1]`, each SEQ_W bits.
  - On accept with src < NODES:
    - If seq ≠ `exp[src]`, `err_seq_count` increments.
    - In both cases `exp[src] <= seq+1`, modulo 2^SEQ_W. The table resynchronises after an error; the wrap from all-ones to 0 is legal.
  - On accept with src ≥ NODES, `err_seq_count` increments and the table is unchanged.
- **Simultaneous errors:** a dest error and a seq error on the same packet increment both counters on the same edge.
- **Counter width:** all counters saturate at all-ones and never wrap.
- **err:** set on any edge that increments either error counter. Cleared only by reset.
- **last_src / last_seq:** updated on every accept, including erroneous packets.
- **Reset values** (asynchronous, while `reset`=0):
  - `busy`=1.
  - All counters, `last_src`, `last_seq` and `err` = 0.
  - `exp[*]`=0.
  - LFSR = seed.

## Timing
- Busy is a one-cycle registered decision. On the first rising edge after `reset` deasserts, `busy` takes `lfsr_next > HOSP`. With HOSP=255, `busy` is 0 from the first edge onward.
- Accept-to-counter latency: 1 cycle. The counters and `last_*` show the new value just after the accepting edge.
- Back-to-back accepts are allowed on consecutive edges when `busy` stays 0; throughput is one packet per cycle at most.
- **Reset mid-packet:** the flit is dropped, not counted, and the table is cleared. The sender must restart its sequence at 0 for every src.
- `valid` while `busy`=1 has no effect on any state.

## Test plan
- **Single packet:**
  - Stimulus: HOSP=255, ID=4; after reset, one flit dest=4, src=2, seq=0.
  - Response: `rx_count`=1; both error counters 0; `last_src`=2; `last_seq`=0; `err`=0.
- **In-order stream:**
  - Stimulus: 100 consecutive flits from src 0..8 interleaved, each with an in-order seq.
  - Response: `rx_count`=100; no errors; no cycle with `busy`=1.
- **Sequence gap:**
  - Stimulus: src=3 sends seq 0, 1, 3, 4.
  - Response: `err_seq_count`=1 after the third packet and stays 1 after the fourth (resync); `err`=1.
- **Wrong destination and bad src together:**
  - Stimulus: flit dest=5 (ID=4), src=12 (≥ NODES).
  - Response: `err_dest_count`=1 and `err_seq_count`=1 on the same edge; `rx_count`=1.
- **Throttle:**
  - Stimulus: HOSP=0 with `valid` held high for 50 cycles.
  - Response: `busy`=1 throughout; `rx_count`=0.
  - Stimulus: HOSP=128.
  - Response: `busy` toggles; `rx_count` equals the number of cycles with `busy`=0.
- **Reset mid-operation:**
  - Stimulus: pulse `reset` low for 1 ns asynchronously after 20 packets.
  - Response: all outputs return to their reset values immediately; a new seq=0 from any src produces no error.
- **Saturation:**
  - Stimulus: force `err_dest_count` to 16'hFFFF, then send a bad-dest packet.
  - Response: `err_dest_count` stays at 16'hFFFF.
